// File: rtl/i2s_slave_port.sv
`timescale 1ns/1ps
// Purpose: I2S slave endpoint that follows an external sclk/lrck pair. It deserialises sd_in into
//          parallel left/right words and serialises the parallel left/right words onto sd_out.
// Latency: the inputs pass 2 sync flops plus a sclk edge-detect flop. rx_valid rises about 2 clk_audio
//          cycles after the strobe for the right word's last bit. sd_out is at most 4 cycles behind falling sclk.
// Backpressure: none. The master's sclk sets the pace. tx_ready/rx_valid/frame_err are
//          one-cycle pulses that the consumer must take when they occur.
//
// Ports:
//   clk_audio           oversampling clock, at least 8x sclk
//   reset               asynchronous, active-high
//   sclk_in/lrck_in     bit clock and word select from the master (asynchronous)
//   sd_in               serial data from the master (asynchronous)
//   sd_out              serial data to the master, registered
//   l_data_tx/r_data_tx words to send; captured at each left-slot start
//   tx_ready            pulse when the tx words are captured for the frame now starting
//   l_data_rx/r_data_rx last complete received frame
//   rx_valid            pulse when l/r_data_rx update
//   frame_err           pulse when a slot ends before DATA_W data bits arrive
module i2s_slave_port #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32
) (
    input  logic              clk_audio,
    input  logic              reset,
    input  logic              sclk_in,
    input  logic              lrck_in,
    input  logic              sd_in,
    output logic              sd_out,
    input  logic [DATA_W-1:0] l_data_tx,
    input  logic [DATA_W-1:0] r_data_tx,
    output logic              tx_ready,
    output logic [DATA_W-1:0] l_data_rx,
    output logic [DATA_W-1:0] r_data_rx,
    output logic              rx_valid,
    output logic              frame_err
);

    // The bit counters only need to count to DATA_W, which is always below SLOT_W.
    localparam int CNT_W = (SLOT_W > 2) ? $clog2(SLOT_W) : 1;
    localparam logic [CNT_W-1:0] DATA_W_C = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    typedef enum logic {SYNC, ACTIVE} state_t;

    // Synchronizers. sd and lrck take the same path length as sclk_s2 so that they
    // are stable and aligned when the rise strobe is evaluated.
    logic sclk_s1, sclk_s2, sclk_s3;
    logic lrck_s1, lrck_s2;
    logic sd_s1, sd_s2;

    always_ff @(posedge clk_audio or posedge reset) begin
        if (reset) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            lrck_s1 <= 1'b0;
            lrck_s2 <= 1'b0;
            sd_s1   <= 1'b0;
            sd_s2   <= 1'b0;
        end else begin
            sclk_s1 <= sclk_in;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            lrck_s1 <= lrck_in;
            lrck_s2 <= lrck_s1;
            sd_s1   <= sd_in;
            sd_s2   <= sd_s1;
        end
    end

    logic rise, fall;
    assign rise = sclk_s2 & ~sclk_s3;
    assign fall = ~sclk_s2 & sclk_s3;

    state_t            state;
    logic              lrck_prev;     // lrck seen at the previous rise
    logic              slot_r;        // 0 = left slot in progress, 1 = right
    logic [CNT_W-1:0]  bit_cnt;       // rx data bits taken in the current slot
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] l_stage;       // completed left word waiting for its right partner
    logic              left_ok;       // l_stage belongs to the current frame
    logic              rx_done;       // right word completed last cycle
    logic [DATA_W-1:0] l_hold, r_hold;
    logic              load_pending;  // a slot started and its word goes out at the next fall
    logic [DATA_W-1:0] tx_shift;
    logic [CNT_W-1:0]  tx_cnt;        // tx bits driven in the current slot

    logic              lrck_chg, left_start;
    logic [DATA_W-1:0] rx_next, tx_next, tx_word;

    assign lrck_chg   = rise && (lrck_s2 != lrck_prev);
    assign left_start = lrck_chg && lrck_prev && !lrck_s2;
    assign rx_next    = DATA_W'({rx_shift, sd_s2});
    assign tx_next    = tx_shift << 1;
    assign tx_word    = slot_r ? r_hold : l_hold;

    always_ff @(posedge clk_audio or posedge reset) begin
        if (reset) begin
            state        <= SYNC;
            lrck_prev    <= 1'b0;
            slot_r       <= 1'b0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            l_stage      <= '0;
            left_ok      <= 1'b0;
            rx_done      <= 1'b0;
            l_hold       <= '0;
            r_hold       <= '0;
            load_pending <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            sd_out       <= 1'b0;
            tx_ready     <= 1'b0;
            l_data_rx    <= '0;
            r_data_rx    <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            tx_ready  <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_done   <= 1'b0;

            if (rise) begin
                lrck_prev <= lrck_s2;
            end

            // The frame is published one cycle after the right word completes.
            // By then rx_shift holds the full right word.
            if (rx_done) begin
                l_data_rx <= l_stage;
                r_data_rx <= rx_shift;
                rx_valid  <= 1'b1;
            end

            case (state)
                SYNC: begin
                    sd_out <= 1'b0;
                    // Lock onto the first left-slot start. That rise begins a frame exactly
                    // as it would in ACTIVE, but it is never a framing error.
                    if (left_start) begin
                        state        <= ACTIVE;
                        slot_r       <= 1'b0;
                        bit_cnt      <= '0;
                        left_ok      <= 1'b0;
                        l_hold       <= l_data_tx;
                        r_hold       <= r_data_tx;
                        tx_ready     <= 1'b1;
                        load_pending <= 1'b1;
                    end
                end

                ACTIVE: begin
                    if (rise) begin
                        if (lrck_chg) begin
                            // The bit sampled here is the previous slot's LSB and is dropped.
                            if (bit_cnt < DATA_W_C) begin
                                frame_err <= 1'b1;
                            end
                            bit_cnt      <= '0;
                            slot_r       <= lrck_s2;
                            load_pending <= 1'b1;
                            if (!lrck_s2) begin
                                left_ok  <= 1'b0;
                                l_hold   <= l_data_tx;
                                r_hold   <= r_data_tx;
                                tx_ready <= 1'b1;
                            end
                        end else if (bit_cnt < DATA_W_C) begin
                            rx_shift <= rx_next;
                            bit_cnt  <= bit_cnt + ONE_C;
                            if (bit_cnt == DATA_W_C - ONE_C) begin
                                if (!slot_r) begin
                                    l_stage <= rx_next;
                                    left_ok <= 1'b1;
                                end else if (left_ok) begin
                                    rx_done <= 1'b1;
                                end
                            end
                        end
                    end

                    if (fall) begin
                        if (load_pending) begin
                            load_pending <= 1'b0;
                            tx_shift     <= tx_word;
                            sd_out       <= tx_word[DATA_W-1];
                            tx_cnt       <= ONE_C;
                        end else if (tx_cnt < DATA_W_C) begin
                            tx_shift <= tx_next;
                            sd_out   <= tx_next[DATA_W-1];
                            tx_cnt   <= tx_cnt + ONE_C;
                        end else begin
                            sd_out <= 1'b0;
                        end
                    end
                end

                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_slave_port.sv
`timescale 1ns/1ps
// Purpose: directed bench for i2s_slave_port. A behavioural I2S master drives sclk/lrck/sd_in
//          and decodes sd_out. Each received word is compared with a table of known values.
// Latency: sclk is 320 ns (about 3.1 MHz) against a 100 MHz clk_audio.
// Backpressure: not applicable.
module tb_i2s_slave_port;

    localparam int DATA_W = 24;
    localparam int SLOT_W = 32;
    localparam int HALF   = 160;

    logic              clk_audio = 1'b0;
    logic              reset;
    logic              sclk_in, lrck_in, sd_in;
    logic              sd_out;
    logic [DATA_W-1:0] l_data_tx, r_data_tx;
    logic              tx_ready;
    logic [DATA_W-1:0] l_data_rx, r_data_rx;
    logic              rx_valid, frame_err;

    i2s_slave_port #(.DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
        .clk_audio (clk_audio),
        .reset     (reset),
        .sclk_in   (sclk_in),
        .lrck_in   (lrck_in),
        .sd_in     (sd_in),
        .sd_out    (sd_out),
        .l_data_tx (l_data_tx),
        .r_data_tx (r_data_tx),
        .tx_ready  (tx_ready),
        .l_data_rx (l_data_rx),
        .r_data_rx (r_data_rx),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always #5 clk_audio = ~clk_audio;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse monitor, sampled on the inactive clock edge.
    int                rxv_cnt = 0;
    int                txr_cnt = 0;
    int                ferr_cnt = 0;
    logic [DATA_W-1:0] last_l = '0;
    logic [DATA_W-1:0] last_r = '0;

    always @(negedge clk_audio) begin
        if (rx_valid) begin
            rxv_cnt = rxv_cnt + 1;
            last_l  = l_data_rx;
            last_r  = r_data_rx;
        end
        if (tx_ready)  txr_cnt  = txr_cnt + 1;
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One sclk period. The master drives on the falling edge and samples sd_out just before the rising edge.
    task automatic bit_period(input logic lr, input logic d, output logic s);
        sclk_in = 1'b0;
        lrck_in = lr;
        sd_in   = d;
        #HALF;
        s       = sd_out;
        sclk_in = 1'b1;
        #HALF;
    endtask

    // One slot of len sclk periods. Data occupies periods 1..DATA_W, MSB first. Any 1 seen on sd_out
    // after the data periods is flagged in tail_nz.
    task automatic slot(input logic lr, input logic [DATA_W-1:0] w, input int len,
                        output logic [DATA_W-1:0] cap, output logic tail_nz);
        logic d, s;
        cap     = '0;
        tail_nz = 1'b0;
        for (int j = 0; j < len; j++) begin
            d = (j >= 1 && j <= DATA_W) ? w[DATA_W-j] : 1'b0;
            bit_period(lr, d, s);
            if (j >= 1 && j <= DATA_W) cap[DATA_W-j] = s;
            else if (j > DATA_W)       tail_nz = tail_nz | s;
        end
    endtask

    logic [DATA_W-1:0] lc, rc, junk;
    logic              t1, t2;
    int                b_rxv, b_txr, b_ferr;

    logic [DATA_W-1:0] vec_l  [3] = '{24'h000001, 24'hFFFFFE, 24'h3C96E1};
    logic [DATA_W-1:0] vec_r  [3] = '{24'h800000, 24'h7FFFFF, 24'hC3691E};
    logic [DATA_W-1:0] vec_tl [3] = '{24'hDEADBE, 24'h000000, 24'hFFFFFF};
    logic [DATA_W-1:0] vec_tr [3] = '{24'h0F1E2D, 24'hAAAAAA, 24'h555555};

    initial begin
        reset     = 1'b1;
        sclk_in   = 1'b1;
        lrck_in   = 1'b0;
        sd_in     = 1'b0;
        l_data_tx = '0;
        r_data_tx = '0;
        repeat (5) @(posedge clk_audio);
        #1;
        check("rst_sd_out",    32'(sd_out),    32'd0);
        check("rst_tx_ready",  32'(tx_ready),  32'd0);
        check("rst_rx_valid",  32'(rx_valid),  32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_l_rx",      32'(l_data_rx), 32'd0);
        check("rst_r_rx",      32'(r_data_rx), 32'd0);
        @(negedge clk_audio);
        reset = 1'b0;

        // The stream begins partway through a right slot, so nothing may happen until lrck goes 1->0.
        l_data_tx = 24'h800001;
        r_data_tx = 24'h123456;
        b_rxv = rxv_cnt; b_txr = txr_cnt;
        slot(1'b1, 24'hFFFFFF, 10, junk, t1);
        check("sync_no_rxv",  32'(rxv_cnt - b_rxv), 32'd0);
        check("sync_no_txr",  32'(txr_cnt - b_txr), 32'd0);
        check("sync_sd_out",  32'(junk), 32'd0);

        // First full frame: receive a pattern and transmit a pattern.
        b_rxv = rxv_cnt; b_txr = txr_cnt; b_ferr = ferr_cnt;
        slot(1'b0, 24'hA5A5A5, SLOT_W, lc, t1);
        slot(1'b1, 24'h5A5A5A, SLOT_W, rc, t2);
        check("f1_rxv_cnt", 32'(rxv_cnt - b_rxv), 32'd1);
        check("f1_l_rx",    32'(last_l), 32'hA5A5A5);
        check("f1_r_rx",    32'(last_r), 32'h5A5A5A);
        check("f1_txr_cnt", 32'(txr_cnt - b_txr), 32'd1);
        check("f1_l_tx",    32'(lc), 32'h800001);
        check("f1_r_tx",    32'(rc), 32'h123456);
        check("f1_tail0",   32'(t1 | t2), 32'd0);
        check("f1_no_ferr", 32'(ferr_cnt - b_ferr), 32'd0);

        // Table frames. r_data_tx changes mid-frame, and the frame must still send the value captured at its start.
        for (int i = 0; i < 3; i++) begin
            b_rxv = rxv_cnt; b_txr = txr_cnt;
            l_data_tx = vec_tl[i];
            r_data_tx = vec_tr[i];
            slot(1'b0, vec_l[i], SLOT_W, lc, t1);
            r_data_tx = ~vec_tr[i];
            slot(1'b1, vec_r[i], SLOT_W, rc, t2);
            check("tbl_rxv_cnt", 32'(rxv_cnt - b_rxv), 32'd1);
            check("tbl_l_rx",    32'(last_l), 32'(vec_l[i]));
            check("tbl_r_rx",    32'(last_r), 32'(vec_r[i]));
            check("tbl_txr_cnt", 32'(txr_cnt - b_txr), 32'd1);
            check("tbl_l_tx",    32'(lc), 32'(vec_tl[i]));
            check("tbl_r_tx",    32'(rc), 32'(vec_tr[i]));
            check("tbl_tail0",   32'(t1 | t2), 32'd0);
        end

        // Short right slot of 16 sclk periods. The frame is discarded, and the error shows at the next left start.
        b_rxv = rxv_cnt; b_ferr = ferr_cnt;
        slot(1'b0, 24'h111111, SLOT_W, lc, t1);
        slot(1'b1, 24'h222222, 16, rc, t2);
        check("short_no_rxv",  32'(rxv_cnt - b_rxv), 32'd0);
        check("short_no_ferr", 32'(ferr_cnt - b_ferr), 32'd0);
        l_data_tx = 24'h654321;
        r_data_tx = 24'hFEDCBA;
        slot(1'b0, 24'h333333, SLOT_W, lc, t1);
        slot(1'b1, 24'h444444, SLOT_W, rc, t2);
        check("short_ferr_cnt", 32'(ferr_cnt - b_ferr), 32'd1);
        check("recov_rxv_cnt",  32'(rxv_cnt - b_rxv), 32'd1);
        check("recov_l_rx",     32'(last_l), 32'h333333);
        check("recov_r_rx",     32'(last_r), 32'h444444);
        check("recov_l_tx",     32'(lc), 32'h654321);
        check("recov_r_tx",     32'(rc), 32'hFEDCBA);

        // Reset for 3 cycles partway through a left slot. The block must resync at the next left start.
        l_data_tx = 24'hFFFFFF;
        slot(1'b0, 24'h777777, 10, lc, t1);
        @(negedge clk_audio);
        reset = 1'b1;
        #1;
        check("mrst_sd_out", 32'(sd_out),    32'd0);
        check("mrst_l_rx",   32'(l_data_rx), 32'd0);
        check("mrst_r_rx",   32'(r_data_rx), 32'd0);
        repeat (3) @(posedge clk_audio);
        @(negedge clk_audio);
        reset = 1'b0;
        b_rxv = rxv_cnt; b_txr = txr_cnt; b_ferr = ferr_cnt;
        slot(1'b0, 24'h777777, SLOT_W - 10, junk, t1);
        slot(1'b1, 24'h888888, SLOT_W, junk, t2);
        check("mrst_no_rxv", 32'(rxv_cnt - b_rxv), 32'd0);
        check("mrst_no_txr", 32'(txr_cnt - b_txr), 32'd0);
        l_data_tx = 24'h0A0B0C;
        r_data_tx = 24'hC0B0A0;
        slot(1'b0, 24'h0F0F0F, SLOT_W, lc, t1);
        slot(1'b1, 24'hF0F0F0, SLOT_W, rc, t2);
        check("resync_rxv_cnt", 32'(rxv_cnt - b_rxv), 32'd1);
        check("resync_txr_cnt", 32'(txr_cnt - b_txr), 32'd1);
        check("resync_l_rx",    32'(last_l), 32'h0F0F0F);
        check("resync_r_rx",    32'(last_r), 32'hF0F0F0);
        check("resync_l_tx",    32'(lc), 32'h0A0B0C);
        check("resync_r_tx",    32'(rc), 32'hC0B0A0);
        check("resync_no_ferr", 32'(ferr_cnt - b_ferr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
